// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster sequencer: phase enum,
// default 640x480@60 timing, test-bar colours and phase helper functions.
package vga_pkg;

    localparam int COLOR_W = 9;
    localparam int CNT_W   = 10;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } phase_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic [COLOR_W-1:0] BAR_0 = 9'h1FF;
    localparam logic [COLOR_W-1:0] BAR_1 = 9'h1F8;
    localparam logic [COLOR_W-1:0] BAR_2 = 9'h03F;
    localparam logic [COLOR_W-1:0] BAR_3 = 9'h038;
    localparam logic [COLOR_W-1:0] BAR_4 = 9'h1C7;
    localparam logic [COLOR_W-1:0] BAR_5 = 9'h1C0;
    localparam logic [COLOR_W-1:0] BAR_6 = 9'h007;
    localparam logic [COLOR_W-1:0] BAR_7 = 9'h000;

    function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] idx);
        logic [COLOR_W-1:0] c;
        case (idx)
            3'd0:    c = BAR_0;
            3'd1:    c = BAR_1;
            3'd2:    c = BAR_2;
            3'd3:    c = BAR_3;
            3'd4:    c = BAR_4;
            3'd5:    c = BAR_5;
            3'd6:    c = BAR_6;
            3'd7:    c = BAR_7;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

    // Next phase given the current phase and the counter value about to be left.
    function automatic phase_e phase_next(input phase_e ph, input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] vis_last,
                                          input logic [CNT_W-1:0] fp_last,
                                          input logic [CNT_W-1:0] sy_last,
                                          input logic [CNT_W-1:0] tot_last);
        phase_e nx;
        case (ph)
            VISIBLE: nx = (cnt == vis_last) ? FRONT   : VISIBLE;
            FRONT:   nx = (cnt == fp_last)  ? SYNC    : FRONT;
            SYNC:    nx = (cnt == sy_last)  ? BACK    : SYNC;
            BACK:    nx = (cnt == tot_last) ? VISIBLE : BACK;
            default: nx = VISIBLE;
        endcase
        return nx;
    endfunction

    function automatic phase_e phase_decode(input logic [CNT_W-1:0] cnt, input int vis,
                                            input int fp, input int sy);
        int c;
        phase_e ph;
        c = int'(cnt);
        if (c < vis) begin
            ph = VISIBLE;
        end else if (c < vis + fp) begin
            ph = FRONT;
        end else if (c < vis + fp + sy) begin
            ph = SYNC;
        end else begin
            ph = BACK;
        end
        return ph;
    endfunction

endpackage

// File: rtl/vga_phase_chk.sv
// Checker: the phase FSM state must always match the phase decoded from its counter.
import vga_pkg::*;

module vga_phase_chk #(
    parameter int VIS = 640,
    parameter int FP  = 16,
    parameter int SY  = 96
) (
    input logic             clk,
    input logic             rst,
    input phase_e           phase,
    input logic [CNT_W-1:0] cnt
);

    // Compare state to decoded counter on every clock out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (phase == phase_decode(cnt, VIS, FP, SY))
                else $error("phase state %0d disagrees with counter %0d", phase, cnt);
        end
    end

endmodule

// File: rtl/vga_sync_delay.sv
// DEPTH x W-bit shift register advanced on tick enable, cleared by synchronous reset.
module vga_sync_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Shift by one stage per tick, otherwise hold.
    always_comb begin
        stage_d[0] = en ? d : stage_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = en ? stage_q[i-1] : stage_q[i];
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA raster sequencer: counters, phase FSMs, pixel request and latency-aligned
// sync/video/colour outputs. Optional colour bars under VGA_TEST_PATTERN_EN.
import vga_pkg::*;

module vga_display_ctrl #(
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int PIPE_LAT    = 2,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               pix_req,
    output logic               frame_start,
    output logic               line_start,
    input  logic [COLOR_W-1:0] color_in,
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_on,
    output logic [COLOR_W-1:0] color_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1023 || V_TOTAL > 1023 || PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_cfg
        $error("vga_display_ctrl: timing totals exceed 10 bits or PIPE_LAT outside 1..8");
    end

    localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] H_FP_LAST  = CNT_W'(H_VISIBLE + H_FRONT - 1);
    localparam logic [CNT_W-1:0] H_SY_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_TOT_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_FP_LAST  = CNT_W'(V_VISIBLE + V_FRONT - 1);
    localparam logic [CNT_W-1:0] V_SY_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_TOT_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic             SYNC_LVL   = (SYNC_ACTIVE != 0);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    phase_e           h_phase_q, h_phase_d, v_phase_q, v_phase_d;
    logic             h_wrap_s, v_wrap_s;
    logic             pix_req_s, line_start_s, frame_start_s, hs_raw_s, vs_raw_s;
    logic [2:0]       raw_s, dly_s;

    assign h_wrap_s = (h_cnt_q == H_TOT_LAST);
    assign v_wrap_s = (v_cnt_q == V_TOT_LAST);

    // Counter and phase next-state; vertical side advances only on the h-wrap tick.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        h_phase_d = h_phase_q;
        v_phase_d = v_phase_q;
        if (pix_en) begin
            h_cnt_d   = h_wrap_s ? '0 : h_cnt_q + 10'd1;
            h_phase_d = phase_next(h_phase_q, h_cnt_q, H_VIS_LAST, H_FP_LAST, H_SY_LAST, H_TOT_LAST);
            if (h_wrap_s) begin
                v_cnt_d   = v_wrap_s ? '0 : v_cnt_q + 10'd1;
                v_phase_d = phase_next(v_phase_q, v_cnt_q, V_VIS_LAST, V_FP_LAST, V_SY_LAST, V_TOT_LAST);
            end else begin
                v_cnt_d   = v_cnt_q;
                v_phase_d = v_phase_q;
            end
        end else begin
            h_cnt_d   = h_cnt_q;
            h_phase_d = h_phase_q;
        end
    end

    // Counter and phase state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_phase_q <= VISIBLE;
            v_phase_q <= VISIBLE;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_phase_q <= h_phase_d;
            v_phase_q <= v_phase_d;
        end
    end

    // Undelayed raster flags; pulses are held low while reset is asserted.
    always_comb begin
        pix_req_s     = !rst && (h_phase_q == VISIBLE) && (v_phase_q == VISIBLE);
        line_start_s  = !rst && (h_cnt_q == 10'd0);
        frame_start_s = line_start_s && (v_cnt_q == 10'd0);
        hs_raw_s      = (h_phase_q == SYNC);
        vs_raw_s      = (v_phase_q == SYNC);
    end

    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign pix_req     = pix_req_s;
    assign line_start  = line_start_s;
    assign frame_start = frame_start_s;
    assign raw_s       = {hs_raw_s, vs_raw_s, pix_req_s};

    vga_sync_delay #(.DEPTH(PIPE_LAT), .W(3)) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (raw_s),
        .q   (dly_s)
    );

    assign h_sync   = dly_s[2] ? SYNC_LVL : ~SYNC_LVL;
    assign v_sync   = dly_s[1] ? SYNC_LVL : ~SYNC_LVL;
    assign video_on = dly_s[0];

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx_s;

    vga_sync_delay #(.DEPTH(PIPE_LAT), .W(3)) u_bar_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (h_cnt_q[9:7]),
        .q   (bar_idx_s)
    );

    // Blank gating with colour-bar override.
    always_comb begin
        if (!dly_s[0]) begin
            color_out = '0;
        end else if (test_mode) begin
            color_out = bar_color(bar_idx_s);
        end else begin
            color_out = color_in;
        end
    end
`else
    // Blank gating.
    always_comb begin
        if (dly_s[0]) begin
            color_out = color_in;
        end else begin
            color_out = '0;
        end
    end
`endif

    vga_phase_chk #(.VIS(H_VISIBLE), .FP(H_FRONT), .SY(H_SYNC)) u_h_chk (
        .clk (clk), .rst (rst), .phase (h_phase_q), .cnt (h_cnt_q)
    );
    vga_phase_chk #(.VIS(V_VISIBLE), .FP(V_FRONT), .SY(V_SYNC)) u_v_chk (
        .clk (clk), .rst (rst), .phase (v_phase_q), .cnt (v_cnt_q)
    );

endmodule
